vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the 800x600@72Hz display path; drives the pixel coordinates and blanking that the game renderer consumes.
//  Divides CLK_100MHz into a 50 MHz pixel cadence and counts H/V position.
//  Emits registered CurrentX/CurrentY, HBlank/VBlank, HSync/VSync, a frame-start strobe and a slow game-update tick.
// PARAMETERS
//  H_VISIBLE 800; H_FRONT 56; H_SYNC 120; H_BACK 64 -- horizontal pixels (H_TOTAL = 1040)
//  V_VISIBLE 600; V_FRONT 37; V_SYNC 6; V_BACK 23 -- vertical lines (V_TOTAL = 666)
//  TICK_FRAMES 8 -- frames per GameTick pulse, legal range 1..255
// PORTS
//  CLK_100MHz  in   1   system clock
//  Reset       in   1   synchronous, active-high reset
//  CurrentX    out  11  horizontal position, 0..H_TOTAL-1
//  CurrentY    out  11  vertical position, 0..V_TOTAL-1
//  HBlank      out  1   high when CurrentX >= H_VISIBLE
//  VBlank      out  1   high when CurrentY >= V_VISIBLE
//  HSync       out  1   positive-polarity horizontal sync
//  VSync       out  1   positive-polarity vertical sync
//  PixelEn     out  1   one-CLK strobe marking each pixel advance (every 2nd clock)
//  FrameStart  out  1   one-CLK pulse when the raster enters (0,0)
//  GameTick    out  1   one-CLK pulse, once every TICK_FRAMES frames, at entry to (0,V_VISIBLE)
// BEHAVIOUR
//  - Reset state: phase=0; CurrentX=CurrentY=0; all 1-bit outputs 0; frame counter 0. Applied on the next edge regardless of raster position.
//  - phase toggles every clock. PixelEn = registered (phase==1).
//  - Counter advance happens on clocks where phase==1:
//    - X increments; at H_TOTAL-1 it wraps to 0 and Y increments.
//    - Y wraps to 0 after V_TOTAL-1, simultaneously with the X wrap.
//  - All outputs are registered and aligned to the same edge as CurrentX/CurrentY.
//    - No extra pipeline: the decodes are computed from next-state counter values.
//  - HBlank = X>=800. VBlank = Y>=600.
//  - HSync = 856<=X<976. VSync = 637<=Y<643.
//  - FrameStart: high exactly the clock that X,Y become (0,0). It is not asserted out of reset.
//  - GameTick: 8-bit frame counter increments at each (0,600) entry.
//    - When it reaches TICK_FRAMES-1, GameTick pulses and the counter clears.
//    - With TICK_FRAMES=1, GameTick pulses every frame.
//  - The first frame after Reset is a full frame from (0,0), with no partial frame.
//  - Reset asserted for one cycle mid-line: the next clock shows (0,0) and every output deasserted.
// CONFIGURATION
//  TICK_GEN_EN defined:
//    - frame counter and GameTick logic are compiled in as described above.
//  TICK_GEN_EN undefined:
//    - no frame counter; GameTick is tied to 0.
//    - all other outputs are bit-identical to the defined build.
// STRUCTURE
//  Package vga_timing_pkg holds:
//    - H/V visible/front/sync/back constants and the derived H_TOTAL/V_TOTAL;
//    - the coordinate width COORD_W=11;
//    - the sync polarity constant.
//  Sub-module vga_axis_counter is instantiated twice (H and V).
//    - Inputs: advance enable. Outputs: count, wrap strobe, blank and sync decodes.
//    - The V instance's enable is the H instance's wrap AND'd with the pixel advance.
// TESTING
//  - Reset held 3 clks then released -> CurrentX=0,CurrentY=0, all flags 0; PixelEn first high on the 2nd clock after release.
//  - Run 2080 clks from reset -> CurrentX wraps 1039->0 and CurrentY goes 0->1 on the same edge; HBlank high X=800..1039; HSync high X=856..975 only.
//  - Run one full frame (1040*666*2 clks) -> checks below:
//    - VBlank high for Y=600..665; VSync high Y=637..642 only;
//    - FrameStart exactly once, at (0,0) after Y=665.
//  - TICK_FRAMES=3, run 7 frames -> GameTick pulses at the (0,600) entries of frames 3 and 6 only (1-based), each 1 clk wide.
//  - Assert Reset for 1 clk at X=500,Y=300 -> next clk X=0,Y=0, HBlank/VBlank/HSync/VSync/GameTick=0; frame counter restarts.
//  - Build without TICK_GEN_EN, run 10 frames -> GameTick constant 0; all other outputs match the TICK_GEN_EN build cycle for cycle.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the 800x600@72Hz timing source: porch/sync lengths, coordinate width, sync polarity.
// The frame-tick feature in vga_timing_gen is enabled by defining TICK_GEN_EN.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 11;

  localparam int unsigned H_VISIBLE = 800;
  localparam int unsigned H_FRONT   = 56;
  localparam int unsigned H_SYNC    = 120;
  localparam int unsigned H_BACK    = 64;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 600;
  localparam int unsigned V_FRONT   = 37;
  localparam int unsigned V_SYNC    = 6;
  localparam int unsigned V_BACK    = 23;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned TICK_FRAMES_DEF = 8;

  // Sync pulses are active-high on this display path.
  localparam logic SYNC_POL = 1'b1;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t COORD_ZERO = coord_t'(0);
  localparam coord_t COORD_ONE  = coord_t'(1);

  function automatic logic inWindow(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with terminal-count strobe and registered blank/sync decodes
// computed from the next count, so all outputs land on the same edge as the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Visible = 800,
  parameter int unsigned Front   = 56,
  parameter int unsigned SyncLen = 120,
  parameter int unsigned Back    = 64
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   blank,
  output logic   sync
);

  localparam int unsigned Total = Visible + Front + SyncLen + Back;
  localparam coord_t LastPos    = coord_t'(Total - 1);
  localparam coord_t VisEnd     = coord_t'(Visible);
  localparam coord_t SyncStart  = coord_t'(Visible + Front);
  localparam coord_t SyncEnd    = coord_t'(Visible + Front + SyncLen);

  coord_t nextCount;

  assign wrap = (count == LastPos);

  // Next position: hold, increment, or wrap to zero at the terminal count.
  always_comb begin
    nextCount = count;
    if (advance) begin
      if (wrap) begin
        nextCount = COORD_ZERO;
      end else begin
        nextCount = count + COORD_ONE;
      end
    end else begin
      nextCount = count;
    end
  end

  // Position and decode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= COORD_ZERO;
      blank <= 1'b0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= nextCount;
      blank <= (nextCount >= VisEnd);
      sync  <= inWindow(nextCount, SyncStart, SyncEnd) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: 50 MHz pixel cadence from CLK_100MHz, H/V position, blanking, sync and strobes.
// Define TICK_GEN_EN to build the frame counter behind GameTick; otherwise GameTick stays 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned HVisible    = H_VISIBLE,
  parameter int unsigned HFront      = H_FRONT,
  parameter int unsigned HSyncLen    = H_SYNC,
  parameter int unsigned HBack       = H_BACK,
  parameter int unsigned VVisible    = V_VISIBLE,
  parameter int unsigned VFront      = V_FRONT,
  parameter int unsigned VSyncLen    = V_SYNC,
  parameter int unsigned VBack       = V_BACK,
  parameter int unsigned TICK_FRAMES = TICK_FRAMES_DEF
) (
  input  logic   CLK_100MHz,
  input  logic   Reset,
  output coord_t CurrentX,
  output coord_t CurrentY,
  output logic   HBlank,
  output logic   VBlank,
  output logic   HSync,
  output logic   VSync,
  output logic   PixelEn,
  output logic   FrameStart,
  output logic   GameTick
);

  logic phase;
  logic advance;
  logic hWrap;
  logic vWrap;
  logic vAdvance;

  assign advance  = phase;
  assign vAdvance = hWrap & advance;

  vga_axis_counter #(
    .Visible (HVisible),
    .Front   (HFront),
    .SyncLen (HSyncLen),
    .Back    (HBack)
  ) hAxis (
    .clk     (CLK_100MHz),
    .reset   (Reset),
    .advance (advance),
    .count   (CurrentX),
    .wrap    (hWrap),
    .blank   (HBlank),
    .sync    (HSync)
  );

  vga_axis_counter #(
    .Visible (VVisible),
    .Front   (VFront),
    .SyncLen (VSyncLen),
    .Back    (VBack)
  ) vAxis (
    .clk     (CLK_100MHz),
    .reset   (Reset),
    .advance (vAdvance),
    .count   (CurrentY),
    .wrap    (vWrap),
    .blank   (VBlank),
    .sync    (VSync)
  );

  // Pixel phase and the strobes that ride on the counter advance.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      phase      <= 1'b0;
      PixelEn    <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      phase      <= ~phase;
      PixelEn    <= phase;
      FrameStart <= vAdvance & vWrap;
    end
  end

`ifdef TICK_GEN_EN
  localparam coord_t TickLine  = coord_t'(VVisible - 1);
  localparam logic [7:0] TickLast = 8'(TICK_FRAMES - 1);

  logic [7:0] frameCnt;
  logic       tickEntry;

  // Raster is about to enter (0,VVisible), i.e. the first blanked line.
  assign tickEntry = vAdvance && (CurrentY == TickLine);

  // Frame counter; pulses GameTick on every TICK_FRAMES-th entry into vertical blank.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      frameCnt <= 8'd0;
      GameTick <= 1'b0;
    end else if (tickEntry) begin
      if (frameCnt == TickLast) begin
        frameCnt <= 8'd0;
        GameTick <= 1'b1;
      end else begin
        frameCnt <= frameCnt + 8'd1;
        GameTick <= 1'b0;
      end
    end else begin
      GameTick <= 1'b0;
    end
  end
`else
  logic unusedTickCfg;
  assign unusedTickCfg = |8'(TICK_FRAMES);

  // Tick feature absent: output held low.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      GameTick <= 1'b0;
    end else begin
      GameTick <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a reduced raster instance (7-frame tick run) and a full 800x600 instance (line wrap),
// both compared every clock against a closed-form model of the raster position since reset.
module tb_vga_timing_gen;

`ifdef TICK_GEN_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  // Reduced raster: 26 x 17 positions, 442 pixels = 884 clocks per frame.
  localparam int SHV = 16, SHF = 3, SHS = 4, SHB = 3;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int STICK = 3;
  localparam int SFRAME_CLKS = 2 * (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst;

  logic [10:0] sX, sY, dX, dY;
  logic sHb, sVb, sHs, sVs, sPe, sFs, sGt;
  logic dHb, dVb, dHs, dVs, dPe, dFs, dGt;

  int checks = 0;
  int failures = 0;
  int k = 0;
  int sTicks = 0;
  int sFrames = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .HVisible(SHV), .HFront(SHF), .HSyncLen(SHS), .HBack(SHB),
    .VVisible(SVV), .VFront(SVF), .VSyncLen(SVS), .VBack(SVB),
    .TICK_FRAMES(STICK)
  ) dutS (
    .CLK_100MHz(clk), .Reset(rst), .CurrentX(sX), .CurrentY(sY),
    .HBlank(sHb), .VBlank(sVb), .HSync(sHs), .VSync(sVs),
    .PixelEn(sPe), .FrameStart(sFs), .GameTick(sGt)
  );

  vga_timing_gen dutD (
    .CLK_100MHz(clk), .Reset(rst), .CurrentX(dX), .CurrentY(dY),
    .HBlank(dHb), .VBlank(dVb), .HSync(dHs), .VSync(dVs),
    .PixelEn(dPe), .FrameStart(dFs), .GameTick(dGt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (k=%0d)", tag, obs, expv, k);
    end
  endtask

  // Model: after k clocks out of reset, k/2 pixels have elapsed; everything follows from that.
  task automatic checkDut(input string n,
                          input int hv, input int hf, input int hsl, input int hbk,
                          input int vv, input int vf, input int vsl, input int vbk, input int tick,
                          input logic [10:0] x, input logic [10:0] y,
                          input logic hb, input logic vb, input logic hs, input logic vs,
                          input logic pe, input logic fs, input logic gt);
    int ht, vt, ft, a, ex, ey, ent0, e;
    bit adv, egt;
    ht = hv + hf + hsl + hbk;
    vt = vv + vf + vsl + vbk;
    ft = ht * vt;
    a  = k / 2;
    ex = a % ht;
    ey = (a / ht) % vt;
    adv = (k >= 2) && (k % 2 == 0);
    ent0 = vv * ht;
    egt = 1'b0;
    if (TICK_ON && adv && a >= ent0 && ((a - ent0) % ft) == 0) begin
      e = (a - ent0) / ft + 1;
      egt = (e % tick) == 0;
    end
    chk({n, "_X"}, 32'(x), 32'(ex));
    chk({n, "_Y"}, 32'(y), 32'(ey));
    chk({n, "_HBlank"}, 32'(hb), 32'(ex >= hv));
    chk({n, "_VBlank"}, 32'(vb), 32'(ey >= vv));
    chk({n, "_HSync"}, 32'(hs), 32'((ex >= hv + hf) && (ex < hv + hf + hsl)));
    chk({n, "_VSync"}, 32'(vs), 32'((ey >= vv + vf) && (ey < vv + vf + vsl)));
    chk({n, "_PixelEn"}, 32'(pe), 32'(adv));
    chk({n, "_FrameStart"}, 32'(fs), 32'(adv && (a % ft) == 0));
    chk({n, "_GameTick"}, 32'(gt), 32'(egt));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) k = 0;
      else k++;
      @(negedge clk);
      checkDut("S", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, STICK,
               sX, sY, sHb, sVb, sHs, sVs, sPe, sFs, sGt);
      checkDut("D", 800, 56, 120, 64, 600, 37, 6, 23, 8,
               dX, dY, dHb, dVb, dHs, dVs, dPe, dFs, dGt);
      if (sGt === 1'b1) sTicks++;
      if (sFs === 1'b1) sFrames++;
    end
  endtask

  initial begin
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    sTicks = 0;
    sFrames = 0;
    step(2);
    step(2078);
    chk("D_line_wrap_X", 32'(dX), 32'd0);
    chk("D_line_wrap_Y", 32'(dY), 32'd1);
    step(7 * SFRAME_CLKS - 2080);
    chk("S_ticks_7_frames", 32'(sTicks), TICK_ON ? 32'd2 : 32'd0);
    chk("S_frames_7_frames", 32'(sFrames), 32'd7);

    for (int r = 0; r < 4; r++) begin
      step(int'($urandom_range(1, 3000)));
      rst = 1'b1;
      step(int'($urandom_range(1, 3)));
      rst = 1'b0;
    end

    sTicks = 0;
    step(3 * SFRAME_CLKS);
    chk("S_ticks_after_reset", 32'(sTicks), TICK_ON ? 32'd1 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
